// File: rtl/lfsr_keystream_gen.sv
// lfsr_keystream_gen: Galois LFSR keystream source for the XOR cipher datapath.
// Each transfer advances the register OUT_BITS Galois steps and emits the
// output bit of every step. Taps are latched at load time. After each reseed,
// WARMUP words are discarded before the stream starts. Words are handed over
// on a valid/ready handshake, so a stalled consumer loses no keystream.
// Optional build macro: LFSR_STUCK_DETECT_EN. When it is defined, an all-zero
// successor state in WARM or RUN parks the FSM in IDLE and raises lock_err.

// One Galois step. The output bit is the LSB of the incoming state.
module lfsr_galois_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] s_o,
  output logic             bit_o
);
  assign bit_o = s_i[0];
  assign s_o   = s_i[0] ? ((s_i >> 1) ^ taps_i) : (s_i >> 1);
endmodule

module lfsr_keystream_gen #(
  parameter int WIDTH    = 64,
  parameter int OUT_BITS = 8,
  parameter int WARMUP   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld,
  input  logic [WIDTH-1:0]    seed_i,
  input  logic [WIDTH-1:0]    taps_i,
  input  logic                ks_ready,
  output logic                ks_valid,
  output logic [OUT_BITS-1:0] ks_data,
  output logic                busy,
  output logic                lock_err,
  output logic [WIDTH-1:0]    state_o
);
  localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);

  typedef enum logic [1:0] {ST_IDLE, ST_WARM, ST_RUN} st_e;

  st_e              fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;

  // The word function is an unrolled chain of OUT_BITS single steps.
  logic [OUT_BITS:0][WIDTH-1:0] chain;
  logic [OUT_BITS-1:0]          word_bits;
  logic [WIDTH-1:0]             wnext;

  assign chain[0] = lfsr_q;
  assign wnext    = chain[OUT_BITS];

  for (genvar g = 0; g < OUT_BITS; g++) begin : g_step
    lfsr_galois_step #(.WIDTH(WIDTH)) u_step (
      .s_i    (chain[g]),
      .taps_i (taps_q),
      .s_o    (chain[g+1]),
      .bit_o  (word_bits[g])
    );
  end

  assign ks_valid = (fsm_q == ST_RUN);
  assign ks_data  = ks_valid ? word_bits : '0;
  assign busy     = (fsm_q == ST_WARM);
  assign lock_err = lock_q;
  assign state_o  = lfsr_q;

  // Next-state logic: a load wins over everything. Otherwise WARM free-runs
  // and RUN advances only on an accepted transfer.
  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    taps_d = taps_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;
    if (ld) begin
      lfsr_d = seed_i;
      taps_d = taps_i;
      cnt_d  = WARMUP_C;
      lock_d = 1'b0;
      if (seed_i == '0) begin
        fsm_d  = ST_IDLE;
        lock_d = 1'b1;
      end else if (WARMUP == 0) begin
        fsm_d = ST_RUN;
      end else begin
        fsm_d = ST_WARM;
      end
    end else begin
      case (fsm_q)
        ST_WARM: begin
          lfsr_d = wnext;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) fsm_d = ST_RUN;
`ifdef LFSR_STUCK_DETECT_EN
          if (wnext == '0) begin
            fsm_d  = ST_IDLE;
            lock_d = 1'b1;
          end
`endif
        end
        ST_RUN: begin
          if (ks_ready) begin
            lfsr_d = wnext;
`ifdef LFSR_STUCK_DETECT_EN
            // The transfer that produced the zero state still completes.
            if (wnext == '0) begin
              fsm_d  = ST_IDLE;
              lock_d = 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      lfsr_q <= '0;
      taps_q <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      taps_q <= taps_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end
endmodule
